// File: rtl/seq_pkg.sv
// Shared encodings for the multi-cycle instruction sequencer: opcodes, FSM states and
// PC source selects.
package seq_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ALU0 = 4'b0001;
  localparam logic [3:0] OP_ALU1 = 4'b0010;
  localparam logic [3:0] OP_ALU2 = 4'b0011;
  localparam logic [3:0] OP_ALU3 = 4'b0100;
  localparam logic [3:0] OP_JMP  = 4'b0101;
  localparam logic [3:0] OP_LD   = 4'b0110;
  localparam logic [3:0] OP_ST   = 4'b0111;
  localparam logic [3:0] OP_BR   = 4'b1000;

  localparam logic [1:0] PC_INC = 2'd0;
  localparam logic [1:0] PC_JMP = 2'd1;
  localparam logic [1:0] PC_BR  = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ALU0) && (op <= OP_ALU3);
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Control/memory bundle between the sequencer (master) and the datapath/memory (slave).
interface instr_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             run;
  logic [19:0]      instruction;
  logic             mem_ack;
  logic             alu_zero;
  logic             mem_req;
  logic             mem_we;
  logic             addr_sel;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             reg_write;
  logic             wb_sel;
  logic             alu_en;
  logic             illegal;
  logic             fault;
  logic [CNT_W-1:0] instr_retired;

  modport master (
    input  run, instruction, mem_ack, alu_zero,
    output mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_write, wb_sel, alu_en,
           illegal, fault, instr_retired
  );

  modport slave (
    output run, instruction, mem_ack, alu_zero,
    input  mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_write, wb_sel, alu_en,
           illegal, fault, instr_retired
  );
endinterface

// File: rtl/seq_timeout_timer.sv
// Cycle counter for a pending memory access; expired_o flags the last permitted wait cycle.
module seq_timeout_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int unsigned CntW = $clog2(MEM_TIMEOUT);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CntW'(MEM_TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory timeout, illegal-opcode halt
// and a retired-instruction counter.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input logic                clk,
  input logic                rst,
  instr_sequencer_if.master  bus
);
  state_e           state_q, state_d;
  logic [3:0]       opcode_q, opcode_d;
  logic             illegal_q, illegal_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic             tmr_clear, tmr_en, tmr_expired;
  logic             unused_instr_bits;

  assign unused_instr_bits = ^bus.instruction[15:0];

  seq_timeout_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (tmr_clear),
    .enable_i (tmr_en),
    .expired_o(tmr_expired)
  );

  // Each FETCH/MEM visit starts a fresh wait window.
  assign tmr_clear = ((state_d == StFetch) || (state_d == StMem)) && (state_d != state_q);
  assign tmr_en    = ((state_q == StFetch) || (state_q == StMem)) && !bus.mem_ack;

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    illegal_d     = illegal_q;
    fault_d       = fault_q;
    retire        = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.addr_sel  = 1'b0;
    bus.ir_write  = 1'b0;
    bus.pc_write  = 1'b0;
    bus.pc_src    = PC_INC;
    bus.reg_write = 1'b0;
    bus.wb_sel    = 1'b0;
    bus.alu_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.run) state_d = StFetch;
      end
      StFetch: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          bus.ir_write = 1'b1;
          opcode_d     = bus.instruction[19:16];
          state_d      = StDecode;
        end else if (tmr_expired) begin
          fault_d = 1'b1;
          state_d = StHalt;
        end
      end
      StDecode: begin
        if (opcode_q == OP_NOP) begin
          bus.pc_write = 1'b1;
          retire       = 1'b1;
          state_d      = StFetch;
        end else if (opcode_q > OP_BR) begin
          illegal_d = 1'b1;
          state_d   = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StFetch;
        if (is_alu_op(opcode_q)) begin
          bus.alu_en    = 1'b1;
          bus.reg_write = 1'b1;
          bus.pc_write  = 1'b1;
          retire        = 1'b1;
        end else if (opcode_q == OP_JMP) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = PC_JMP;
          retire       = 1'b1;
        end else if (opcode_q == OP_BR) begin
          bus.alu_en   = 1'b1;
          bus.pc_write = 1'b1;
          bus.pc_src   = bus.alu_zero ? PC_BR : PC_INC;
          retire       = 1'b1;
        end else if ((opcode_q == OP_LD) || (opcode_q == OP_ST)) begin
          bus.alu_en = 1'b1;
          state_d    = StMem;
        end
      end
      StMem: begin
        bus.mem_req  = 1'b1;
        bus.addr_sel = 1'b1;
        bus.mem_we   = (opcode_q == OP_ST);
        if (bus.mem_ack) begin
          if (opcode_q == OP_ST) begin
            bus.pc_write = 1'b1;
            retire       = 1'b1;
            state_d      = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (tmr_expired) begin
          fault_d = 1'b1;
          state_d = StHalt;
        end
      end
      StWb: begin
        bus.reg_write = 1'b1;
        bus.wb_sel    = 1'b1;
        bus.pc_write  = 1'b1;
        retire        = 1'b1;
        state_d       = StFetch;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: state_d = StIdle;
    endcase

    cnt_d = cnt_q + CNT_W'(retire);
  end

  assign bus.illegal       = illegal_q;
  assign bus.fault         = fault_q;
  assign bus.instr_retired = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      opcode_q  <= OP_NOP;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench: each issued instruction queues its expected final-retire strobes and
// latency; the monitor pops and compares whenever pc_write fires.
module tb_instr_sequencer;
  import seq_pkg::*;

  typedef struct {
    logic [1:0] pc_src;
    logic       reg_write;
    logic       wb_sel;
    logic       alu_en;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_sequencer_if #(.CNT_W(16)) bus ();
  instr_sequencer_if #(.CNT_W(4))  bus4 ();

  assign bus4.run         = bus.run;
  assign bus4.instruction = bus.instruction;
  assign bus4.mem_ack     = bus.mem_ack;
  assign bus4.alu_zero    = bus.alu_zero;

  instr_sequencer #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  instr_sequencer #(.MEM_TIMEOUT(16), .CNT_W(4)) dut4 (
    .clk(clk),
    .rst(rst),
    .bus(bus4)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   retired = 0;
  bit   prev_fetch = 1'b0;
  bit   cnt_pending = 1'b0;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    bit   fetch_now;
    if (cnt_pending) begin
      check("retired", 32'(bus.instr_retired), retired);
      check("retired_w4", 32'(bus4.instr_retired), retired % 16);
      cnt_pending = 1'b0;
    end
    fetch_now = bus.mem_req && !bus.addr_sel;
    if (fetch_now && !prev_fetch) start_cyc = cyc;
    prev_fetch = fetch_now;
    if (bus.pc_write) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pc_write", 32'(bus.pc_write), 0);
      end else begin
        e = sb_q.pop_front();
        check("pc_src", 32'(bus.pc_src), 32'(e.pc_src));
        check("reg_write", 32'(bus.reg_write), 32'(e.reg_write));
        check("wb_sel", 32'(bus.wb_sel), 32'(e.wb_sel));
        check("alu_en", 32'(bus.alu_en), 32'(e.alu_en));
        check("latency", cyc - start_cyc + 1, e.lat);
        retired++;
        cnt_pending = 1'b1;
      end
    end
  endtask

  // Samples between edges, then advances one clock.
  task automatic tick();
    #1;
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_for(input bit want_mem, output bit ok);
    int n = 0;
    ok = 1'b1;
    while (!(bus.mem_req && (bus.addr_sel == want_mem)) && (n < 40)) begin
      tick();
      n++;
    end
    if (!(bus.mem_req && (bus.addr_sel == want_mem))) begin
      check(want_mem ? "wait_mem" : "wait_fetch", {bus.mem_req, bus.addr_sel}, {1'b1, want_mem});
      ok = 1'b0;
    end
  endtask

  task automatic do_reset();
    sb_q.delete();
    bus.mem_ack = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    retired = 0;
    cnt_pending = 1'b0;
    prev_fetch = 1'b0;
  endtask

  task automatic do_instr(input logic [3:0] op, input int fd, input int md, input logic z);
    exp_t e;
    bit   ok;
    bit   is_mem;
    int   n;
    is_mem      = (op == OP_LD) || (op == OP_ST);
    e.pc_src    = (op == OP_JMP) ? PC_JMP : ((op == OP_BR) && z) ? PC_BR : PC_INC;
    e.reg_write = ((op >= OP_ALU0) && (op <= OP_ALU3)) || (op == OP_LD);
    e.wb_sel    = (op == OP_LD);
    e.alu_en    = ((op >= OP_ALU0) && (op <= OP_ALU3)) || (op == OP_BR);
    e.lat       = ((op == OP_NOP) ? 2 : (op == OP_ST) ? 4 : (op == OP_LD) ? 5 : 3) + fd
                  + (is_mem ? md : 0);
    sb_q.push_back(e);
    bus.instruction = {op, 16'hA5C3};
    bus.alu_zero    = z;
    bus.mem_ack     = 1'b0;
    wait_for(1'b0, ok);
    if (!ok) begin
      sb_q.delete();
      return;
    end
    repeat (fd) begin
      check("fetch_hold", {bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_write}, 4'b1000);
      tick();
    end
    bus.mem_ack = 1'b1;
    #1;
    check("ir_write", 32'(bus.ir_write), 1);
    tick();
    bus.mem_ack = 1'b0;
    if (is_mem) begin
      wait_for(1'b1, ok);
      if (!ok) begin
        sb_q.delete();
        return;
      end
      repeat (md + 1) begin
        if (cyc >= 0) begin
          check("mem_hold", {bus.mem_req, bus.mem_we, bus.addr_sel}, {1'b1, op == OP_ST, 1'b1});
        end
        if (sb_q.size() != 0 && md == 0) break;
        tick();
        md--;
        if (md < 0) break;
      end
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
    end
    n = 0;
    while ((sb_q.size() != 0) && (n < 10)) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0) begin
      check("retire_seen", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  initial begin
    int  n;
    bit  ok;
    bus.run         = 1'b0;
    bus.instruction = '0;
    bus.mem_ack     = 1'b0;
    bus.alu_zero    = 1'b0;
    do_reset();

    check("rst_strobes", {bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_write, bus.pc_write,
                          bus.reg_write, bus.wb_sel, bus.alu_en}, 8'h00);
    check("rst_flags", {bus.illegal, bus.fault}, 2'b00);
    check("rst_retired", 32'(bus.instr_retired), 0);
    tick();
    check("idle_hold", 32'(bus.mem_req), 0);

    bus.run = 1'b1;
    do_instr(OP_ALU0, 0, 0, 1'b0);
    bus.run = 1'b0;
    do_instr(OP_JMP, 0, 0, 1'b0);
    do_instr(OP_BR, 0, 0, 1'b1);
    do_instr(OP_BR, 0, 0, 1'b0);
    do_instr(OP_ALU3, 2, 0, 1'b0);
    do_instr(OP_ST, 0, 1, 1'b0);
    do_instr(OP_LD, 0, 3, 1'b0);
    do_instr(OP_NOP, 0, 0, 1'b0);
    do_instr(OP_ALU1, 15, 0, 1'b0);
    do_instr(OP_ST, 1, 15, 1'b0);
    tick();
    check("no_fault_boundary", 32'(bus.fault), 0);

    // Fetch timeout.
    do_reset();
    bus.run         = 1'b1;
    bus.instruction = 20'h1_0000;
    tick();
    n = 0;
    while (bus.mem_req && !bus.addr_sel && (n < 40)) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, 16);
    check("fault_set", 32'(bus.fault), 1);
    bus.mem_ack = 1'b1;
    tick();
    tick();
    check("halt_no_req", {bus.mem_req, bus.pc_write}, 2'b00);
    check("fault_sticky", 32'(bus.fault), 1);
    bus.mem_ack = 1'b0;
    bus.run     = 1'b0;
    do_reset();
    check("fault_cleared", 32'(bus.fault), 0);

    // Illegal opcode.
    bus.run         = 1'b1;
    bus.instruction = 20'hF_0000;
    wait_for(1'b0, ok);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("illegal_no_pcw", 32'(bus.pc_write), 0);
    tick();
    check("illegal_set", 32'(bus.illegal), 1);
    repeat (3) tick();
    check("illegal_halt", {bus.mem_req, bus.illegal}, 2'b01);
    bus.run = 1'b0;
    do_reset();
    check("illegal_cleared", 32'(bus.illegal), 0);
    tick();
    check("idle_after_rst", 32'(bus.mem_req), 0);

    // Reset while a store waits in MEM.
    bus.run         = 1'b1;
    bus.instruction = {OP_ST, 16'h0000};
    wait_for(1'b0, ok);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    wait_for(1'b1, ok);
    tick();
    check("store_wait", {bus.mem_req, bus.mem_we, bus.addr_sel}, 3'b111);
    bus.run = 1'b0;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_drops_req", 32'(bus.mem_req), 0);
    check("rst_no_retire", 32'(bus.instr_retired), 0);
    tick();
    check("rst_idle", 32'(bus.mem_req), 0);

    // Counter wrap on the narrow instance.
    do_reset();
    bus.run = 1'b1;
    repeat (17) do_instr(OP_NOP, 0, 0, 1'b0);
    tick();
    check("wrap_w16", 32'(bus.instr_retired), 17);
    check("wrap_w4", 32'(bus4.instr_retired), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks",
             n_errors, n_checks);
    $fatal(1);
  end
endmodule
